// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// Imported by the channel and top-level modules.
package clk_div_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int DIV_MIN   = 1;

    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/pending divisor, level and strobe.
// A new divisor is staged and only takes effect on this channel's wrap.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] val,
    output logic             out,
    output logic             tick
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(DIV_MIN);
    localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] active;
    logic [CNT_W-1:0] pending;
    logic             pend;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] half;
    logic             wrap;

    assign cnt_inc = cnt + ONE;
    assign half    = active >> 1;
    assign wrap    = sync || (cnt == active - ONE);

    // Count, wrap, apply staged divisor on wrap; a write on the wrap edge waits a period.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= DEF - ONE;
            active  <= DEF;
            pending <= '0;
            pend    <= 1'b0;
            out     <= 1'b0;
            tick    <= 1'b0;
        end else begin
            if (en || sync) begin
                if (wrap) begin
                    cnt  <= '0;
                    tick <= 1'b1;
                    out  <= 1'b1;
                    if (pend) begin
                        active <= pending;
                        pend   <= 1'b0;
                    end
                end else begin
                    cnt  <= cnt_inc;
                    tick <= 1'b0;
                    out  <= (cnt_inc < half);
                end
            end else begin
                tick <= 1'b0;
            end
            if (wr) begin
                pending <= val;
                pend    <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel programmable integer clock divider.
// Validates divisor writes, acknowledges them, and fans out to channels.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter  int NUM_CH  = 4,
    parameter  int CNT_W   = CNT_W_DEF,
    parameter  int DEF_DIV = 2,
    localparam int CH_W    = ch_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sync,
    input  logic              div_wr,
    input  logic [CH_W-1:0]   div_ch,
    input  logic [CNT_W-1:0]  div_val,
    output logic              div_ack,
    output logic              div_err,
    output logic [NUM_CH-1:0] div_out,
    output logic [NUM_CH-1:0] div_tick
);

    localparam logic [CH_W:0] NCH = (CH_W + 1)'(NUM_CH);

    logic              wr_ok;
    logic [NUM_CH-1:0] wr_sel;

    assign wr_ok = div_wr && ({1'b0, div_ch} < NCH) && (div_val != '0);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr_sel[i] = wr_ok && (div_ch == CH_W'(i));

        clk_div_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .sync (sync),
            .wr   (wr_sel[i]),
            .val  (div_val),
            .out  (div_out[i]),
            .tick (div_tick[i])
        );
    end

    // Acknowledge every write one cycle later; flag rejected ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_ack <= 1'b0;
            div_err <= 1'b0;
        end else begin
            div_ack <= div_wr;
            div_err <= div_wr && !wr_ok;
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed self-checking bench for clk_div_prog.
// Five channels so an out-of-range channel index is representable.
module tb_clk_div_prog;

    localparam int NUM_CH  = 5;
    localparam int CNT_W   = 16;
    localparam int DEF_DIV = 2;
    localparam int CH_W    = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              sync;
    logic              div_wr;
    logic [CH_W-1:0]   div_ch;
    logic [CNT_W-1:0]  div_val;
    logic              div_ack;
    logic              div_err;
    logic [NUM_CH-1:0] div_out;
    logic [NUM_CH-1:0] div_tick;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] po;
    logic [7:0] pt;

    always #5 clk = ~clk;

    clk_div_prog #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sync     (sync),
        .div_wr   (div_wr),
        .div_ch   (div_ch),
        .div_val  (div_val),
        .div_ack  (div_ack),
        .div_err  (div_err),
        .div_out  (div_out),
        .div_tick (div_tick)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_wr(input int ch, input int val, input logic exp_err);
        div_wr  = 1'b1;
        div_ch  = CH_W'(ch);
        div_val = CNT_W'(val);
        step();
        div_wr  = 1'b0;
        check("ack", 32'(div_ack), 32'd1);
        check("err", 32'(div_err), 32'(exp_err));
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b0;
        sync    = 1'b0;
        div_wr  = 1'b0;
        div_ch  = '0;
        div_val = '0;
        step();
        step();
        check("rst_out",  32'(div_out),  32'h0);
        check("rst_tick", 32'(div_tick), 32'h0);
        check("rst_ack",  32'(div_ack),  32'h0);
        check("rst_err",  32'(div_err),  32'h0);

        // default N=2: first enabled edge wraps
        rst = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t1_out",  32'(div_out),  (i % 2 == 0) ? 32'h1f : 32'h0);
            check("t1_tick", 32'(div_tick), (i % 2 == 0) ? 32'h1f : 32'h0);
        end
        step();

        // ch1 N=5 written mid-period
        do_wr(1, 5, 1'b0);
        check("t2_old", 32'(div_out[1]), 32'd0);
        po = 8'b0010_0011;
        pt = 8'b0010_0001;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 0) check("t2_ack_clr", 32'(div_ack), 32'd0);
            check("t2_out",  32'(div_out[1]),  32'(po[i]));
            check("t2_tick", 32'(div_tick[1]), 32'(pt[i]));
        end

        // rejected writes: zero divisor, channel out of range
        do_wr(0, 0, 1'b1);
        check("t3_o0", 32'(div_out[0]), 32'd1);
        do_wr(NUM_CH, 3, 1'b1);
        check("t3_o1", 32'(div_out[0]), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_out",  32'(div_out[0]),  (i % 2 == 0) ? 32'd1 : 32'd0);
            check("t3_tick", 32'(div_tick[0]), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        check("t3_ch1", 32'(div_tick[1]), 32'd1);

        // ch2 N=7, freeze during high phase
        do_wr(2, 7, 1'b0);
        check("t4_pre", 32'(div_out[2]), 32'd0);
        step();
        check("t4_wrap", 32'(div_tick[2]), 32'd1);
        step();
        step();
        check("t4_hi", 32'(div_out[2]), 32'd1);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("t4_frz_out",  32'(div_out),  32'h1d);
            check("t4_frz_tick", 32'(div_tick), 32'h0);
        end
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4_res_out",  32'(div_out[2]),  (i == 4) ? 32'd1 : 32'd0);
            check("t4_res_tick", 32'(div_tick[2]), (i == 4) ? 32'd1 : 32'd0);
        end

        // ch0 N=3 written on its wrap edge, ch1 N=4, then sync
        do_wr(0, 3, 1'b0);
        do_wr(1, 4, 1'b0);
        step();
        check("t5_same_edge", 32'(div_tick[0]), 32'd1);
        for (int i = 0; i < 4; i++) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("t5_sync_out",  32'(div_out),  32'h1f);
        check("t5_sync_tick", 32'(div_tick), 32'h1f);
        for (int k = 1; k < 8; k++) begin
            step();
            check("t5_o0", 32'(div_out[0]),  (k % 3 == 0) ? 32'd1 : 32'd0);
            check("t5_t0", 32'(div_tick[0]), (k % 3 == 0) ? 32'd1 : 32'd0);
            check("t5_o1", 32'(div_out[1]),  (k % 4 < 2) ? 32'd1 : 32'd0);
            check("t5_t1", 32'(div_tick[1]), (k % 4 == 0) ? 32'd1 : 32'd0);
        end

        // pending ch3 N=9 discarded by reset; rst beats a same-edge write
        do_wr(3, 9, 1'b0);
        rst     = 1'b1;
        div_wr  = 1'b1;
        div_ch  = 3'd4;
        div_val = 16'd7;
        step();
        div_wr = 1'b0;
        rst    = 1'b0;
        check("t6_out",  32'(div_out),  32'h0);
        check("t6_tick", 32'(div_tick), 32'h0);
        check("t6_ack",  32'(div_ack),  32'h0);
        step();
        check("t6_first", 32'(div_tick), 32'h1f);
        for (int k = 1; k < 7; k++) begin
            step();
            check("t6_out3", 32'(div_out[3]), (k % 2 == 0) ? 32'd1 : 32'd0);
            check("t6_tick", 32'(div_tick),   (k % 2 == 0) ? 32'h1f : 32'h0);
        end

        // N=1 on ch4: strobe and level high every enabled cycle
        do_wr(4, 1, 1'b0);
        check("t7_pre", 32'(div_out[4]), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t7_out",  32'(div_out[4]),  32'd1);
            check("t7_tick", 32'(div_tick[4]), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
